// File: rtl/regfile_writeback_ctrl.sv
// Write-back controller for a 32x32 register file: arbitrates ALU and load results
// onto one registered write port and tracks outstanding loads. Optional forwarding: WB_BYPASS_EN.
module regfile_writeback_ctrl #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // ALU result channel
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  // load result channel
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  // load issue and hazard lookup
  input  logic        iss_load,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
`ifdef WB_BYPASS_EN
  output logic        rs1_fwd_hit,
  output logic        rs2_fwd_hit,
  output logic [31:0] rs1_fwd_data,
  output logic [31:0] rs2_fwd_data,
`endif
  // register-file write port
  output logic        regWrite,
  output logic [4:0]  writeRegister,
  output logic [31:0] writeData
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LD
  } src_e;

  logic [3:0]  r_wait_cnt;
  logic [31:0] r_sb;

  logic        w_load_prio;
  logic        w_ld_acc;
  logic        w_alu_acc;
  src_e        w_src;
  logic [4:0]  w_win_rd;
  logic [31:0] w_win_data;
  logic        w_win_write;
  logic [3:0]  w_wait_nxt;
  logic [31:0] w_sb_nxt;

  // Arbitration: the ALU normally wins; a load blocked MAX_WAIT cycles in a row takes over.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    w_src       = SRC_NONE;
    w_win_rd    = '0;
    w_win_data  = '0;
    w_load_prio = (r_wait_cnt == MAX_W);
    ld_ready    = w_load_prio | ~alu_valid;
    alu_stall   = w_load_prio & alu_valid;
    w_ld_acc    = ld_valid & ld_ready;
    w_alu_acc   = alu_valid & ~alu_stall;

    if (w_ld_acc) begin
      w_src      = SRC_LD;
      w_win_rd   = ld_rd;
      w_win_data = ld_data;
    end else if (w_alu_acc) begin
      w_src      = SRC_ALU;
      w_win_rd   = alu_rd;
      w_win_data = alu_data;
    end

    // x0 winners still complete their handshake but never reach the file.
    w_win_write = (w_src != SRC_NONE) && (w_win_rd != 5'd0);
  end

  always_comb begin
    w_wait_nxt = '0;
    if (ld_valid && !w_ld_acc) begin
      w_wait_nxt = (r_wait_cnt >= MAX_W) ? MAX_W : r_wait_cnt + 4'd1;
    end
  end

  // Clear on acceptance first, then set on issue, so a same-cycle reissue keeps the bit.
  always_comb begin
    w_sb_nxt = r_sb;
    if (w_ld_acc) begin
      w_sb_nxt[ld_rd] = 1'b0;
    end
    if (iss_load && (iss_rd != 5'd0)) begin
      w_sb_nxt[iss_rd] = 1'b1;
    end
    w_sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_sb       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_wait_cnt <= w_wait_nxt;
      r_sb       <= w_sb_nxt;
    end
  end

  // Address and data only move on a real write; idle cycles hold the last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
    end else begin
      regWrite <= w_win_write;
      if (w_win_write) begin
        writeRegister <= w_win_rd;
        writeData     <= w_win_data;
      end
    end
  end

  // Lookups see the scoreboard as it stood before this cycle's updates.
  always_comb begin
    rs1_busy = (rs1 != 5'd0) && r_sb[rs1];
    rs2_busy = (rs2 != 5'd0) && r_sb[rs2];
  end

`ifdef WB_BYPASS_EN
  // Covers a read of the register being written this cycle in a file with no internal bypass.
  always_comb begin
    rs1_fwd_hit  = regWrite && (writeRegister == rs1) && (rs1 != 5'd0);
    rs2_fwd_hit  = regWrite && (writeRegister == rs2) && (rs2 != 5'd0);
    rs1_fwd_data = writeData;
    rs2_fwd_data = writeData;
  end
`endif

endmodule
